bus_rr_arbiter: RTL

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin drain of NUM_SRC registered-empty FIFOs onto one shared bus.
// Two-stage issue/capture pipeline with a one-entry skid behind the output register.
module bus_rr_arbiter #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned ID_LEN   = $clog2(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_SRC-1:0]          src_empty,
  output logic [NUM_SRC-1:0]          src_rd_en,
  input  logic [NUM_SRC*DATA_LEN-1:0] src_rd_data,
  output logic [DATA_LEN-1:0]         bus_data,
  output logic [ID_LEN-1:0]           bus_src_id,
  output logic                        bus_valid,
  input  logic                        bus_ready
);

  typedef struct packed {
    logic [ID_LEN-1:0]   id;
    logic [DATA_LEN-1:0] data;
  } word_t;

  logic               run_q;
  logic [NUM_SRC-1:0] prev_rd_q;
  logic [ID_LEN-1:0]  last_grant_q, last_grant_d;
  logic               inflight_q, inflight_d;
  logic [ID_LEN-1:0]  inflight_id_q, inflight_id_d;
  logic               out_valid_q, out_valid_d;
  word_t              out_q, out_d;
  logic               skid_valid_q, skid_valid_d;
  word_t              skid_q, skid_d;

  logic [NUM_SRC-1:0]  elig_c;
  logic [NUM_SRC-1:0]  rd_en_c;
  logic                accept_c;
  logic                room_c;
  logic                grant_found_c;
  logic                issue_c;
  logic [ID_LEN-1:0]   grant_idx_c;
  logic [1:0]          occ_c;
  logic [DATA_LEN-1:0] cap_data_c;
  word_t               cap_c;
  int unsigned         cand;

  // Issue stage: a source just read is skipped to cover its empty-flag lag.
  always_comb begin
    elig_c        = ~src_empty & ~prev_rd_q;
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    cand          = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = 32'(last_grant_q) + i + 1;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!grant_found_c && elig_c[cand[ID_LEN-1:0]]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = cand[ID_LEN-1:0];
      end
    end
    accept_c = out_valid_q & bus_ready;
    occ_c    = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q);
    room_c   = (occ_c - 2'(accept_c)) < 2'd2;
    issue_c  = run_q & grant_found_c & room_c;
    rd_en_c  = issue_c ? (NUM_SRC'(1) << grant_idx_c) : '0;
  end

  assign src_rd_en = rd_en_c;

  // Capture stage: select the slice of the source read last cycle.
  always_comb begin
    cap_data_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (inflight_id_q == ID_LEN'(k)) cap_data_c = src_rd_data[k*DATA_LEN +: DATA_LEN];
    end
    cap_c.id   = inflight_id_q;
    cap_c.data = cap_data_c;
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    inflight_d    = issue_c;
    inflight_id_d = inflight_id_q;
    out_valid_d   = out_valid_q;
    out_d         = out_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    if (issue_c) begin
      last_grant_d  = grant_idx_c;
      inflight_id_d = grant_idx_c;
    end
    // Acceptance frees the output register, refilled from the skid if it holds a word.
    if (accept_c) begin
      out_valid_d  = skid_valid_q;
      if (skid_valid_q) out_d = skid_q;
      skid_valid_d = 1'b0;
    end
    if (inflight_q) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_d       = cap_c;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = cap_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q         <= 1'b0;
      prev_rd_q     <= '0;
      last_grant_q  <= ID_LEN'(NUM_SRC - 1);
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      out_valid_q   <= 1'b0;
      out_q         <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
    end else begin
      run_q         <= 1'b1;
      prev_rd_q     <= rd_en_c;
      last_grant_q  <= last_grant_d;
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      out_valid_q   <= out_valid_d;
      out_q         <= out_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
    end
  end

  assign bus_data   = out_q.data;
  assign bus_src_id = out_q.id;
  assign bus_valid  = out_valid_q;

endmodule
